// File: rtl/row_col_release.sv
// Return-path row table for the row/column unique-ID remapper.
// Restores original IDs on responses and frees rows on their last return.
module row_col_release #(
  parameter int ID_WIDTH        = 4,
  parameter int MAX_OUTSTANDING = 16,
  localparam int IDX = $clog2(MAX_OUTSTANDING),
  localparam int UW  = 2 * IDX
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alloc_valid,
  input  logic [UW-1:0]              alloc_unique_id,
  input  logic [ID_WIDTH-1:0]        alloc_id,
  input  logic                       rsp_valid,
  output logic                       rsp_ready,
  input  logic [UW-1:0]              rsp_unique_id,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ID_WIDTH-1:0]        out_id,
  output logic [UW-1:0]              out_unique_id,
  output logic                       out_last,
  output logic [MAX_OUTSTANDING-1:0] row_free,
  output logic                       err_unmapped,
  output logic                       err_order,
  output logic                       err_alloc
);

  localparam logic [IDX:0] CMAX = (IDX+1)'(MAX_OUTSTANDING);
  localparam logic [IDX:0] CONE = (IDX+1)'(1);

  logic [MAX_OUTSTANDING-1:0] used_q;
  logic [MAX_OUTSTANDING-1:0] used_n;
  logic [ID_WIDTH-1:0]        id_q   [MAX_OUTSTANDING];
  logic [ID_WIDTH-1:0]        id_n   [MAX_OUTSTANDING];
  logic [IDX:0]               cnt_q  [MAX_OUTSTANDING];
  logic [IDX:0]               cnt_n  [MAX_OUTSTANDING];
  logic [IDX-1:0]             head_q [MAX_OUTSTANDING];
  logic [IDX-1:0]             head_n [MAX_OUTSTANDING];

  logic [IDX-1:0] a_row;
  logic [IDX-1:0] r_row;
  logic [IDX-1:0] r_col;
  logic           a_hit;
  logic           a_match;
  logic           a_sat;
  logic           a_inc;
  logic           acc;
  logic           r_hit;
  logic           r_miss;
  logic           same;
  logic           r_free;
  logic           ord_bad;
  logic           alloc_bad;
  logic           unused_alloc_col;

  assign a_row = alloc_unique_id[UW-1:IDX];
  assign r_row = rsp_unique_id[UW-1:IDX];
  assign r_col = rsp_unique_id[IDX-1:0];
  assign unused_alloc_col = ^alloc_unique_id[IDX-1:0];

  assign rsp_ready = !out_valid || out_ready;
  assign acc       = rsp_valid && rsp_ready;

  assign a_hit     = alloc_valid && used_q[a_row];
  assign a_match   = a_hit && (id_q[a_row] == alloc_id);
  assign a_sat     = a_match && (cnt_q[a_row] == CMAX);
  assign a_inc     = a_match && !a_sat;
  assign alloc_bad = a_hit && (!a_match || a_sat);

  assign r_hit   = acc && used_q[r_row];
  assign r_miss  = acc && !used_q[r_row];
  // A matching alloc in the same cycle keeps the row alive.
  assign same    = r_hit && a_match && (a_row == r_row);
  assign r_free  = r_hit && (cnt_q[r_row] == CONE) && !same;
  assign ord_bad = r_hit && (r_col != head_q[r_row]);

  always_comb begin
    used_n = used_q;
    id_n   = id_q;
    cnt_n  = cnt_q;
    head_n = head_q;
    if (alloc_valid && !used_q[a_row]) begin
      used_n[a_row] = 1'b1;
      id_n[a_row]   = alloc_id;
      cnt_n[a_row]  = CONE;
    end else if (a_inc) begin
      cnt_n[a_row] = cnt_q[a_row] + CONE;
    end
    if (r_hit) begin
      cnt_n[r_row]  = cnt_n[r_row] - CONE;
      head_n[r_row] = head_q[r_row] + 1'b1;
      if (r_free) used_n[r_row] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      used_q <= '0;
      for (int j = 0; j < MAX_OUTSTANDING; j++) begin
        id_q[j]   <= '0;
        cnt_q[j]  <= '0;
        head_q[j] <= '0;
      end
      row_free <= '1;
    end else begin
      used_q   <= used_n;
      id_q     <= id_n;
      cnt_q    <= cnt_n;
      head_q   <= head_n;
      row_free <= ~used_n;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid     <= 1'b0;
      out_id        <= '0;
      out_unique_id <= '0;
      out_last      <= 1'b0;
      err_unmapped  <= 1'b0;
      err_order     <= 1'b0;
      err_alloc     <= 1'b0;
    end else begin
      err_unmapped <= r_miss;
      err_order    <= ord_bad;
      err_alloc    <= alloc_bad;
      if (r_hit) begin
        out_valid     <= 1'b1;
        out_id        <= id_q[r_row];
        out_unique_id <= rsp_unique_id;
        out_last      <= r_free;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_row_col_release.sv
// Directed bench for row_col_release.
// Linear stimulus, hand-computed expectations, immediate assertions.
module tb_row_col_release;

  logic        clk;
  logic        rst;
  logic        alloc_valid;
  logic [7:0]  alloc_unique_id;
  logic [3:0]  alloc_id;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_unique_id;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_id;
  logic [7:0]  out_unique_id;
  logic        out_last;
  logic [15:0] row_free;
  logic        err_unmapped;
  logic        err_order;
  logic        err_alloc;

  int total;
  int fails;

  row_col_release #(.ID_WIDTH(4), .MAX_OUTSTANDING(16)) dut (
    .clk(clk),
    .rst(rst),
    .alloc_valid(alloc_valid),
    .alloc_unique_id(alloc_unique_id),
    .alloc_id(alloc_id),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_unique_id(rsp_unique_id),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_id(out_id),
    .out_unique_id(out_unique_id),
    .out_last(out_last),
    .row_free(row_free),
    .err_unmapped(err_unmapped),
    .err_order(err_order),
    .err_alloc(err_alloc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    fails = 0;
    rst = 1'b0;
    alloc_valid = 1'b0;
    alloc_unique_id = '0;
    alloc_id = '0;
    rsp_valid = 1'b0;
    rsp_unique_id = '0;
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_row_free", row_free, 16'hFFFF);
    chk("rst_rsp_ready", rsp_ready, 1);
    chk("rst_errs", {err_unmapped, err_order, err_alloc}, 0);

    // Row 2: two allocations, two in-order returns
    alloc_valid = 1'b1; alloc_unique_id = 8'h20; alloc_id = 4'hA;
    tick();
    alloc_unique_id = 8'h21;
    tick();
    alloc_valid = 1'b0;
    chk("r2_alloc_free", row_free, 16'hFFFB);
    rsp_valid = 1'b1; rsp_unique_id = 8'h20;
    tick();
    chk("r2_v1", out_valid, 1);
    chk("r2_id1", out_id, 4'hA);
    chk("r2_uid1", out_unique_id, 8'h20);
    chk("r2_last1", out_last, 0);
    chk("r2_free1", row_free, 16'hFFFB);
    rsp_unique_id = 8'h21;
    tick();
    chk("r2_id2", out_id, 4'hA);
    chk("r2_last2", out_last, 1);
    chk("r2_ord2", err_order, 0);
    chk("r2_free2", row_free, 16'hFFFF);
    rsp_valid = 1'b0;
    tick();
    chk("r2_idle", out_valid, 0);

    // Backpressure on row 4
    alloc_valid = 1'b1; alloc_unique_id = 8'h40; alloc_id = 4'h3;
    tick();
    alloc_unique_id = 8'h41;
    tick();
    alloc_valid = 1'b0;
    out_ready = 1'b0;
    rsp_valid = 1'b1; rsp_unique_id = 8'h40;
    tick();
    chk("bp_v", out_valid, 1);
    chk("bp_uid", out_unique_id, 8'h40);
    rsp_unique_id = 8'h41;
    #1;
    chk("bp_ready_lo", rsp_ready, 0);
    tick();
    chk("bp_hold_v", out_valid, 1);
    chk("bp_hold_uid", out_unique_id, 8'h40);
    chk("bp_hold_id", out_id, 4'h3);
    chk("bp_hold_last", out_last, 0);
    out_ready = 1'b1;
    #1;
    chk("bp_ready_hi", rsp_ready, 1);
    tick();
    rsp_valid = 1'b0;
    chk("bp_rel_v", out_valid, 1);
    chk("bp_rel_uid", out_unique_id, 8'h41);
    chk("bp_rel_last", out_last, 1);
    tick();
    chk("bp_idle", out_valid, 0);
    chk("bp_free", row_free, 16'hFFFF);

    // Response to unused row 5
    rsp_valid = 1'b1; rsp_unique_id = 8'h50;
    tick();
    rsp_valid = 1'b0;
    chk("um_err", err_unmapped, 1);
    chk("um_v", out_valid, 0);
    chk("um_free", row_free, 16'hFFFF);
    tick();
    chk("um_pulse", err_unmapped, 0);

    // Out-of-order return on row 3
    alloc_valid = 1'b1; alloc_unique_id = 8'h30; alloc_id = 4'h6;
    tick();
    alloc_unique_id = 8'h31;
    tick();
    alloc_valid = 1'b0;
    rsp_valid = 1'b1; rsp_unique_id = 8'h31;
    tick();
    rsp_valid = 1'b0;
    chk("ord_err", err_order, 1);
    chk("ord_id", out_id, 4'h6);
    chk("ord_last", out_last, 0);
    chk("ord_free", row_free, 16'hFFF7);
    tick();
    chk("ord_pulse", err_order, 0);
    rsp_valid = 1'b1; rsp_unique_id = 8'h30;
    tick();
    rsp_valid = 1'b0;
    chk("ord_err2", err_order, 1);
    chk("ord_last2", out_last, 1);
    chk("ord_free2", row_free, 16'hFFFF);
    tick();

    // Same-cycle alloc and response on row 7
    alloc_valid = 1'b1; alloc_unique_id = 8'h70; alloc_id = 4'h9;
    tick();
    alloc_unique_id = 8'h71;
    rsp_valid = 1'b1; rsp_unique_id = 8'h70;
    tick();
    alloc_valid = 1'b0;
    rsp_valid = 1'b0;
    chk("sc_v", out_valid, 1);
    chk("sc_id", out_id, 4'h9);
    chk("sc_last", out_last, 0);
    chk("sc_free", row_free, 16'hFF7F);
    chk("sc_alloc_err", err_alloc, 0);
    tick();
    rsp_valid = 1'b1; rsp_unique_id = 8'h71;
    tick();
    rsp_valid = 1'b0;
    chk("sc_last2", out_last, 1);
    chk("sc_ord2", err_order, 0);
    chk("sc_free2", row_free, 16'hFFFF);
    tick();

    // Saturation on row 8
    alloc_id = 4'h2;
    for (int k = 0; k < 16; k++) begin
      alloc_valid = 1'b1;
      alloc_unique_id = 8'h80 | k[7:0];
      tick();
      chk($sformatf("sat_ok%0d", k), err_alloc, 0);
    end
    alloc_unique_id = 8'h80;
    tick();
    chk("sat_err", err_alloc, 1);
    alloc_id = 4'h5;
    tick();
    alloc_valid = 1'b0;
    chk("mis_err", err_alloc, 1);
    tick();
    chk("alloc_pulse", err_alloc, 0);
    chk("sat_free", row_free, 16'hFEFF);
    for (int k = 0; k < 16; k++) begin
      rsp_valid = 1'b1;
      rsp_unique_id = 8'h80 | k[7:0];
      tick();
      chk($sformatf("drain_id%0d", k), out_id, 4'h2);
      chk($sformatf("drain_last%0d", k), out_last, (k == 15) ? 1 : 0);
    end
    rsp_valid = 1'b0;
    chk("drain_free", row_free, 16'hFFFF);
    tick();

    // Reset while a response is held
    alloc_valid = 1'b1; alloc_unique_id = 8'h10; alloc_id = 4'h7;
    tick();
    alloc_valid = 1'b0;
    alloc_unique_id = 8'h11;
    alloc_valid = 1'b1;
    tick();
    alloc_valid = 1'b0;
    out_ready = 1'b0;
    rsp_valid = 1'b1; rsp_unique_id = 8'h10;
    tick();
    rsp_valid = 1'b0;
    chk("mr_held", out_valid, 1);
    rst = 1'b0;
    #1;
    chk("mr_v", out_valid, 0);
    chk("mr_free", row_free, 16'hFFFF);
    chk("mr_ready", rsp_ready, 1);
    tick();
    rst = 1'b1;
    out_ready = 1'b1;
    rsp_valid = 1'b1; rsp_unique_id = 8'h11;
    tick();
    rsp_valid = 1'b0;
    chk("mr_unmapped", err_unmapped, 1);
    chk("mr_no_out", out_valid, 0);
    tick();

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/row_col_release.md
Name: row_col_release

Overview:
- Return-path companion to the row/column unique-ID allocator in the AXI ID-remapping reorder logic.
- Mirrors every allocation issued on the request side into its own row table (row → original master ID, outstanding count, expected column).
- Accepts responses tagged with a unique ID, restores the original ID, and frees a row when its last outstanding transaction returns.
- Publishes the per-row free vector back to the allocator.

Parameters:
- ID_WIDTH, 4, width of the original master ID.
- MAX_OUTSTANDING, 16, number of rows and columns (N). IDX = $clog2(MAX_OUTSTANDING); unique ID = {row[IDX-1:0], col[IDX-1:0]}.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-low reset.
- alloc_valid  input  1  one-cycle pulse, concurrent with the allocator's valid_id.
- alloc_unique_id  input  2*IDX  unique ID just issued.
- alloc_id  input  ID_WIDTH  original ID bound to that unique ID.
- rsp_valid  input  1  response present.
- rsp_ready  output  1  response accepted when rsp_valid && rsp_ready.
- rsp_unique_id  input  2*IDX  unique ID carried by the response.
- out_valid  output  1  restored response valid.
- out_ready  input  1  downstream accept.
- out_id  output  ID_WIDTH  restored original ID.
- out_unique_id  output  2*IDX  unique ID of the restored response.
- out_last  output  1  this response freed its row.
- row_free  output  MAX_OUTSTANDING  bit j = 1 when row j is unused.
- err_unmapped  output  1  one-cycle pulse: response hit an unused row.
- err_order  output  1  one-cycle pulse: response column ≠ expected column.
- err_alloc  output  1  one-cycle pulse: allocation ID mismatch or count overflow.

Behaviour:
Per-row state:
- used (1b), id (ID_WIDTH), cnt (IDX+1 bits, 0..MAX_OUTSTANDING), head_col (IDX bits).

Reset (rst=0, async):
- All rows: used=0, id=0, cnt=0, head_col=0.
- out_valid=0, out_id=0, out_unique_id=0, out_last=0, all err_* = 0.
- row_free = all ones; rsp_ready = 1.
- Reset asserted mid-transfer discards any held output and the entire table; nothing is replayed.

Allocation, registered at posedge, row r = alloc_unique_id[2*IDX-1:IDX]:
- Row unused: used←1, id←alloc_id, cnt←1.
- Row used and id==alloc_id: cnt←cnt+1.
- Row used and id≠alloc_id: table unchanged, err_alloc pulse.
- cnt==MAX_OUTSTANDING: cnt saturates, err_alloc pulse.
- The alloc column is not checked.

Response stage (single registered output stage):
- rsp_ready = !out_valid || out_ready (combinational).
- Accept on rsp_valid && rsp_ready; row r and column c come from rsp_unique_id.
- Row used:
  - Next cycle: out_valid=1, out_id=id[r], out_unique_id=rsp_unique_id.
  - cnt←cnt−1; head_col←(head_col+1) mod MAX_OUTSTANDING.
  - If cnt was 1: used←0, out_last=1; otherwise out_last=0.
  - If c≠head_col: err_order pulse; the response is still forwarded.
- Row unused: response dropped, no out_valid, table unchanged, err_unmapped pulse.
- Latency: accept → out_valid is 1 cycle.
- While out_valid && !out_ready, all out_* hold stable.
- Handshake at out_valid && out_ready with no new accept: out_valid←0.
- Back-to-back accepts sustain 1 response/cycle when out_ready=1.

Rules:
- head_col persists across free and reuse; only reset clears it. This matches the allocator's non-resetting column counter.
- Simultaneous alloc and response on the same used row: net cnt unchanged; row never freed in that cycle, so out_last=0 even if cnt was 1. ID restore uses the pre-edge id.
- Simultaneous alloc to an unused row and response to that same row: response sees the pre-edge state → err_unmapped; allocation proceeds.
- row_free is registered from used (reflects post-edge table).
- err_* are registered one-cycle pulses, independent of out_ready.

Test Plan:
- Reset: drive rst=0 mid-stream → out_valid=0, row_free=16'hFFFF, rsp_ready=1.
- Allocate uid {r=2,c=0} and {r=2,c=1} with id=4'hA, then return c=0 and c=1 with out_ready=1:
  - Outputs out_id=4'hA twice, out_last=0 then 1.
  - row_free[2] returns to 1 one cycle after the second accept.
- Backpressure: hold out_ready=0 with out_valid=1 and present a second response → rsp_ready=0, out_* stable; release → second response out on the following cycle.
- Response to unused row 5 → err_unmapped=1 for one cycle, out_valid stays 0, table unchanged.
- Allocate row 3 cols 0,1; return col 1 first → err_order=1, out_id correct, cnt=1, row 3 still used.
- Same-cycle alloc and response on row 7 with cnt=1 → out_last=0, row_free[7]=0, cnt stays 1. Then 16 allocations to row 8 → cnt=16 saturates; the 17th raises err_alloc.
